// File: rtl/bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bus_ctrl_pkg
// Shared definitions for the register-transfer bus controller: the default
// register count and the transfer FSM state encoding.
// ---------------------------------------------------------------------------
package bus_ctrl_pkg;

  // Number of bus-attached registers unless the instantiator overrides it.
  localparam int NREG_DEFAULT = 8;

  // A transfer walks IDLE -> DRIVE -> LOAD -> HOLD -> IDLE, one cycle each.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2,
    HOLD  = 2'd3
  } xfer_state_t;

endpackage

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// ---------------------------------------------------------------------------
// onehot_dec
// Register index to one-hot decoder with an enable. With i_en low the output
// is all-zero, which is how the controller floats the bus or withholds a load.
//
// Ports:
//   i_idx     register index
//   i_en      enable; 0 forces o_onehot to zero
//   o_onehot  one-hot vector, bit i_idx set when enabled
// ---------------------------------------------------------------------------
module onehot_dec
  import bus_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int IW   = $clog2(NREG)
) (
  input  logic [IW-1:0]   i_idx,
  input  logic            i_en,
  output logic [NREG-1:0] o_onehot
);

  // Plain decode; at most one bit can ever be set by construction.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// bus_xfer_ctrl
// Moves one register's value to another over a shared tristate bus. Two
// requesters (A = instruction decoder, B = debug/host) are arbitrated
// round-robin. Each transfer drives the source onto the bus, pulses the
// destination's load strobe, then holds the bus one more cycle while
// reporting completion.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   a_valid/a_src/a_dst port A request;  a_ready = accepted this cycle
//   b_valid/b_src/b_dst port B request;  b_ready = accepted this cycle
//   tri_en              one-hot bus driver enable (zero = bus floating)
//   load_en             one-hot register load strobe (used as a clock)
//   busy                controller is in a transfer
//   done, done_port     completion pulse and the port it belonged to
// ---------------------------------------------------------------------------
module bus_xfer_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int IW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [IW-1:0]   a_src,
  input  logic [IW-1:0]   a_dst,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [IW-1:0]   b_src,
  input  logic [IW-1:0]   b_dst,
  output logic            b_ready,
  output logic [NREG-1:0] tri_en,
  output logic [NREG-1:0] load_en,
  output logic            busy,
  output logic            done,
  output logic            done_port
);

  xfer_state_t     r_state;
  logic            r_lastB;
  logic [IW-1:0]   r_src;
  logic [IW-1:0]   r_dst;
  logic            r_port;
  logic [NREG-1:0] r_triEn;
  logic [NREG-1:0] r_loadEn;
  logic            r_busy;
  logic            r_done;
  logic            r_donePort;

  logic            w_idle;
  logic            w_grantA;
  logic            w_grantB;
  logic            w_grant;
  logic [IW-1:0]   w_triIdx;
  logic            w_triOn;
  logic            w_loadOn;
  logic [NREG-1:0] w_triNext;
  logic [NREG-1:0] w_loadNext;

  // Round-robin grant. r_lastB remembers who won last; on a tie the other
  // port wins. Reset leaves r_lastB set so that A is favoured first.
  assign w_idle   = (r_state == IDLE);
  assign w_grantA = w_idle & a_valid & (~b_valid | r_lastB);
  assign w_grantB = w_idle & b_valid & (~a_valid | ~r_lastB);
  assign w_grant  = w_grantA | w_grantB;
  assign a_ready  = w_grantA;
  assign b_ready  = w_grantB;

  // The decoders look one cycle ahead: they compute what the enables must be
  // in the next state, and the flops below present them. That keeps tri_en
  // and load_en straight off flops, so load_en cannot glitch. While idle and
  // granting, the source comes from the winning port; afterwards from the
  // captured copy, so input changes mid-transfer are ignored.
  assign w_triIdx = w_idle ? (w_grantB ? b_src : a_src) : r_src;
  assign w_triOn  = (w_idle & w_grant) | (r_state == DRIVE) | (r_state == LOAD);
  assign w_loadOn = (r_state == DRIVE);

  onehot_dec #(.NREG(NREG), .IW(IW)) u_triDec (
    .i_idx    (w_triIdx),
    .i_en     (w_triOn),
    .o_onehot (w_triNext)
  );

  onehot_dec #(.NREG(NREG), .IW(IW)) u_loadDec (
    .i_idx    (r_dst),
    .i_en     (w_loadOn),
    .o_onehot (w_loadNext)
  );

  // Transfer FSM with all outputs registered. Asynchronous reset clears the
  // enables immediately, which abandons any transfer in flight without a
  // done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastB     <= 1'b1;
      r_src       <= '0;
      r_dst       <= '0;
      r_port      <= 1'b0;
      r_triEn     <= '0;
      r_loadEn    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_donePort  <= 1'b0;
    end else begin
      r_triEn  <= w_triNext;
      r_loadEn <= w_loadNext;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_src   <= w_triIdx;
            r_dst   <= w_grantB ? b_dst : a_dst;
            r_port  <= w_grantB;
            r_lastB <= w_grantB;
            r_busy  <= 1'b1;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          r_state <= LOAD;
        end
        LOAD: begin
          r_done     <= 1'b1;
          r_donePort <= r_port;
          r_state    <= HOLD;
        end
        HOLD: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tri_en    = r_triEn;
  assign load_en   = r_loadEn;
  assign busy      = r_busy;
  assign done      = r_done;
  assign done_port = r_donePort;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_xfer_ctrl
// Self-checking bench for bus_xfer_ctrl with a cycle-level reference model
// and a scoreboard of expected completion ports.
// ---------------------------------------------------------------------------
module tb_bus_xfer_ctrl;

  localparam int NREG = 8;
  localparam int IW   = 3;

  logic            clk;
  logic            rst;
  logic            a_valid;
  logic [IW-1:0]   a_src;
  logic [IW-1:0]   a_dst;
  logic            a_ready;
  logic            b_valid;
  logic [IW-1:0]   b_src;
  logic [IW-1:0]   b_dst;
  logic            b_ready;
  logic [NREG-1:0] tri_en;
  logic [NREG-1:0] load_en;
  logic            busy;
  logic            done;
  logic            done_port;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 drive, 2 load, 3 hold.
  int            mPhase;
  logic          mLastB;
  logic [IW-1:0] mSrc;
  logic [IW-1:0] mDst;
  bit            sbQ[$];
  logic          obsA, obsB;
  logic          lastGA, lastGB;

  bus_xfer_ctrl #(.NREG(NREG), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_src     (a_src),
    .a_dst     (a_dst),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_src     (b_src),
    .b_dst     (b_dst),
    .b_ready   (b_ready),
    .tri_en    (tri_en),
    .load_en   (load_en),
    .busy      (busy),
    .done      (done),
    .done_port (done_port)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and on a miss counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPhase = 0;
    mLastB = 1'b1;
    mSrc   = '0;
    mDst   = '0;
    sbQ.delete();
    lastGA = 1'b0;
    lastGB = 1'b0;
  endtask

  // Holds reset across one rising edge, checks the reset values, releases.
  // Returns 1 time unit after a rising edge.
  task automatic applyReset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_tri_en", 32'(tri_en), 32'h0);
    checkOutput("rst_load_en", 32'(load_en), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_done_port", 32'(done_port), 32'h0);
    rst = 1'b0;
    modelReset();
  endtask

  // One clock cycle: predict and check ready, push expected port on a grant,
  // advance the model over the edge, then check every output and the
  // scoreboard. Entered and left 1 time unit after a rising edge.
  task automatic applyStimulus();
    logic          gA, gB;
    logic [IW-1:0] nSrc, nDst;
    logic [7:0]    expTri, expLoad;
    bit            expPort;
    #1;
    gA = 1'b0;
    gB = 1'b0;
    if (mPhase == 0) begin
      if (a_valid && b_valid) begin
        gA = mLastB;
        gB = !mLastB;
      end else begin
        gA = a_valid;
        gB = b_valid;
      end
    end
    obsA = a_ready;
    obsB = b_ready;
    checkOutput("a_ready", 32'(a_ready), 32'(gA));
    checkOutput("b_ready", 32'(b_ready), 32'(gB));
    nSrc = gB ? b_src : a_src;
    nDst = gB ? b_dst : a_dst;
    if (gA) sbQ.push_back(1'b0);
    if (gB) sbQ.push_back(1'b1);
    @(posedge clk);
    if (mPhase == 0) begin
      if (gA || gB) begin
        mPhase = 1;
        mSrc   = nSrc;
        mDst   = nDst;
        mLastB = gB;
      end
    end else begin
      mPhase = (mPhase + 1) % 4;
    end
    #1;
    expTri  = (mPhase != 0) ? (8'h01 << mSrc) : 8'h00;
    expLoad = (mPhase == 2) ? (8'h01 << mDst) : 8'h00;
    checkOutput("tri_en", 32'(tri_en), 32'(expTri));
    checkOutput("load_en", 32'(load_en), 32'(expLoad));
    checkOutput("busy", 32'(busy), 32'(mPhase != 0));
    checkOutput("done", 32'(done), 32'(mPhase == 3));
    checkOutput("tri_onehot", 32'($countones(tri_en) <= 1), 32'h1);
    checkOutput("load_onehot", 32'($countones(load_en) <= 1), 32'h1);
    if (done === 1'b1) begin
      checkOutput("sb_has_entry", 32'(sbQ.size() > 0), 32'h1);
      if (sbQ.size() > 0) begin
        expPort = sbQ.pop_front();
        checkOutput("done_port", 32'(done_port), 32'(expPort));
      end
    end
    lastGA = gA;
    lastGB = gB;
  endtask

  initial begin
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_src = '0;
    a_dst = '0;
    b_src = '0;
    b_dst = '0;
    rst = 1'b1;
    modelReset();
    applyReset();

    // Single A transfer, src 3 -> dst 5.
    $display("[TB] single A transfer");
    a_valid = 1'b1; a_src = 3'd3; a_dst = 3'd5;
    applyStimulus();
    a_valid = 1'b0;
    checkOutput("a36_c0_a_ready", 32'(obsA), 32'h1);
    checkOutput("a36_c1_tri", 32'(tri_en), 32'h08);
    checkOutput("a36_c1_load", 32'(load_en), 32'h00);
    applyStimulus();
    checkOutput("a36_c2_tri", 32'(tri_en), 32'h08);
    checkOutput("a36_c2_load", 32'(load_en), 32'h20);
    applyStimulus();
    checkOutput("a36_c3_tri", 32'(tri_en), 32'h08);
    checkOutput("a36_c3_load", 32'(load_en), 32'h00);
    checkOutput("a36_c3_done", 32'(done), 32'h1);
    checkOutput("a36_c3_port", 32'(done_port), 32'h0);
    applyStimulus();
    checkOutput("a36_c4_busy", 32'(busy), 32'h0);
    checkOutput("a36_c4_tri", 32'(tri_en), 32'h00);

    // Both ports requesting continuously from reset: A, B, A.
    $display("[TB] round-robin A/B");
    applyReset();
    a_valid = 1'b1; a_src = 3'd1; a_dst = 3'd2;
    b_valid = 1'b1; b_src = 3'd4; b_dst = 3'd6;
    applyStimulus();
    checkOutput("rr_c0_a_ready", 32'(obsA), 32'h1);
    checkOutput("rr_c0_b_ready", 32'(obsB), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus();
    applyStimulus();
    checkOutput("rr_c4_b_ready", 32'(obsB), 32'h1);
    checkOutput("rr_c4_a_ready", 32'(obsA), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus();
    applyStimulus();
    checkOutput("rr_c8_a_ready", 32'(obsA), 32'h1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus();

    // B alone, src == dst == 7.
    $display("[TB] B self-reload");
    b_valid = 1'b1; b_src = 3'd7; b_dst = 3'd7;
    applyStimulus();
    b_valid = 1'b0;
    applyStimulus();
    checkOutput("b38_c2_tri", 32'(tri_en), 32'h80);
    checkOutput("b38_c2_load", 32'(load_en), 32'h80);
    applyStimulus();
    checkOutput("b38_c3_done", 32'(done), 32'h1);
    checkOutput("b38_c3_port", 32'(done_port), 32'h1);
    applyStimulus();

    // Reset asserted during LOAD, between clock edges.
    $display("[TB] reset during LOAD");
    a_valid = 1'b1; a_src = 3'd2; a_dst = 3'd0;
    applyStimulus();
    a_valid = 1'b0;
    applyStimulus();
    checkOutput("r39_load_before", 32'(load_en), 32'h01);
    #2 rst = 1'b1;
    #1;
    checkOutput("r39_tri_async", 32'(tri_en), 32'h00);
    checkOutput("r39_load_async", 32'(load_en), 32'h00);
    checkOutput("r39_busy_async", 32'(busy), 32'h0);
    modelReset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("r39_no_done", 32'(done), 32'h0);
    checkOutput("r39_idle", 32'(busy), 32'h0);
    a_valid = 1'b1; a_src = 3'd6; a_dst = 3'd1;
    applyStimulus();
    a_valid = 1'b0;
    applyStimulus();
    checkOutput("r39_next_load", 32'(load_en), 32'h02);
    applyStimulus();
    checkOutput("r39_next_done", 32'(done), 32'h1);
    applyStimulus();

    // Random traffic; requesters hold requests until granted and scramble
    // their idle inputs while the transfer runs.
    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      if (lastGA) begin
        a_valid = 1'b0;
        a_src = 3'($urandom_range(0, 7));
        a_dst = 3'($urandom_range(0, 7));
      end
      if (lastGB) begin
        b_valid = 1'b0;
        b_src = 3'($urandom_range(0, 7));
        b_dst = 3'($urandom_range(0, 7));
      end
      if (!a_valid && $urandom_range(0, 2) == 0) begin
        a_valid = 1'b1;
        a_src = 3'($urandom_range(0, 7));
        a_dst = 3'($urandom_range(0, 7));
      end
      if (!b_valid && $urandom_range(0, 2) == 0) begin
        b_valid = 1'b1;
        b_src = 3'($urandom_range(0, 7));
        b_dst = 3'($urandom_range(0, 7));
      end
      applyStimulus();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus();
    checkOutput("sb_drained", 32'(sbQ.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
